vdec1_ctrl: RTL and testbench

Block-level sequencer for the rate-1/3 Viterbi decoder (code blocks up to 29 info bits plus 8 tail bits). It accepts decode requests, starts the forward ACS unit that writes survivor decisions into one of two ptram banks, then starts the backward traceback on the filled bank. The two banks work as a ping-pong pair, so the forward pass of block N+1 overlaps the traceback of block N. Decoded bits leave through a valid/ready output port.

---
 rtl/vdec1_ctrl_if.sv | 39 +++
 rtl/vdec1_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vdec1_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdec1_ctrl_if.sv
// Handshake and control bundle between the Viterbi block sequencer and its
// request source, forward ACS unit, traceback unit and decoded-bit sink.
interface vdec1_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_size;

  logic        fwd_start;
  logic [5:0]  fwd_len;
  logic        fwd_bank;
  logic        fwd_done;

  logic        bwd_start;
  logic [5:0]  bwd_len;
  logic        bwd_bank;
  logic        bwd_done;
  logic [28:0] bwd_info;

  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_bits;
  logic [4:0]  out_size;

  logic        busy;
  logic        err_size;
  logic        err_timeout;

  modport master (
    input  req_valid, req_size, fwd_done, bwd_done, bwd_info, out_ready,
    output req_ready, fwd_start, fwd_len, fwd_bank, bwd_start, bwd_len, bwd_bank,
           out_valid, out_bits, out_size, busy, err_size, err_timeout
  );

  modport slave (
    output req_valid, req_size, fwd_done, bwd_done, bwd_info, out_ready,
    input  req_ready, fwd_start, fwd_len, fwd_bank, bwd_start, bwd_len, bwd_bank,
           out_valid, out_bits, out_size, busy, err_size, err_timeout
  );
endinterface

// File: rtl/vdec1_ctrl.sv
// Ping-pong ptram bank sequencer for the rate-1/3 Viterbi forward ACS and traceback units.
// Starts fire one cycle after accept / bank FULL; a stalled out_ready holds the result and blocks the next traceback.
module vdec1_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  vdec1_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       SIZE_MAX = 5'd29;

  typedef enum logic [1:0] {BK_FREE, BK_FWD, BK_FULL, BK_BWD} bank_st_t;

  typedef struct packed {
    bank_st_t   st;
    logic [4:0] size;
  } bank_t;

  typedef enum logic {F_IDLE, F_RUN} f_state_t;
  typedef enum logic [1:0] {B_IDLE, B_RUN, B_HOLD} b_state_t;

  f_state_t         f_state_q, f_state_d;
  b_state_t         b_state_q, b_state_d;
  bank_t [1:0]      bank_q, bank_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [CNT_W-1:0] f_cnt_q, f_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  logic             fwd_start_q, fwd_start_d;
  logic [5:0]       fwd_len_q, fwd_len_d;
  logic             fwd_bank_q, fwd_bank_d;
  logic             bwd_start_q, bwd_start_d;
  logic [5:0]       bwd_len_q, bwd_len_d;
  logic             bwd_bank_q, bwd_bank_d;
  logic             out_valid_q, out_valid_d;
  logic [28:0]      out_bits_q, out_bits_d;
  logic [4:0]       out_size_q, out_size_d;
  logic             err_size_q, err_size_d;
  logic             err_timeout_q, err_timeout_d;

  logic             req_ready_c;
  logic             req_fire;
  logic             size_ok;
  logic             f_abort;
  logic             b_abort;
  logic [28:0]      mask_c;

  assign req_ready_c = (f_state_q == F_IDLE) && (bank_q[wr_q].st == BK_FREE);
  assign req_fire    = bus.req_valid && req_ready_c;
  assign size_ok     = (bus.req_size != 5'd0) && (bus.req_size <= SIZE_MAX);
  // A size of 29 wraps the shifted one to zero, so the subtraction yields all ones.
  assign mask_c      = (29'd1 << bank_q[rd_q].size) - 29'd1;

  always_comb begin
    f_state_d     = f_state_q;
    b_state_d     = b_state_q;
    bank_d        = bank_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    f_cnt_d       = f_cnt_q;
    b_cnt_d       = b_cnt_q;
    fwd_start_d   = 1'b0;
    fwd_len_d     = fwd_len_q;
    fwd_bank_d    = fwd_bank_q;
    bwd_start_d   = 1'b0;
    bwd_len_d     = bwd_len_q;
    bwd_bank_d    = bwd_bank_q;
    out_valid_d   = out_valid_q;
    out_bits_d    = out_bits_q;
    out_size_d    = out_size_q;
    err_size_d    = 1'b0;
    f_abort       = 1'b0;
    b_abort       = 1'b0;
    err_timeout_d = 1'b0;

    unique case (f_state_q)
      F_IDLE: begin
        if (req_fire) begin
          if (size_ok) begin
            f_state_d          = F_RUN;
            bank_d[wr_q].st    = BK_FWD;
            bank_d[wr_q].size  = bus.req_size;
            fwd_start_d        = 1'b1;
            fwd_len_d          = 6'(bus.req_size) + 6'd8;
            fwd_bank_d         = wr_q;
            f_cnt_d            = '0;
          end else begin
            err_size_d = 1'b1;
          end
        end
      end
      F_RUN: begin
        if (bus.fwd_done) begin
          f_state_d       = F_IDLE;
          bank_d[wr_q].st = BK_FULL;
          wr_d            = ~wr_q;
        end else if (f_cnt_q == CNT_MAX) begin
          // Aborted block is discarded; the same bank is reused for the next request.
          f_state_d       = F_IDLE;
          bank_d[wr_q].st = BK_FREE;
          f_abort         = 1'b1;
        end else begin
          f_cnt_d = f_cnt_q + CNT_ONE;
        end
      end
      default: f_state_d = F_IDLE;
    endcase

    unique case (b_state_q)
      B_IDLE: begin
        if (bank_q[rd_q].st == BK_FULL) begin
          b_state_d       = B_RUN;
          bank_d[rd_q].st = BK_BWD;
          bwd_start_d     = 1'b1;
          bwd_len_d       = 6'(bank_q[rd_q].size) + 6'd7;
          bwd_bank_d      = rd_q;
          b_cnt_d         = '0;
        end
      end
      B_RUN: begin
        if (bus.bwd_done) begin
          b_state_d       = B_HOLD;
          bank_d[rd_q].st = BK_FREE;
          rd_d            = ~rd_q;
          out_valid_d     = 1'b1;
          out_bits_d      = bus.bwd_info & mask_c;
          out_size_d      = bank_q[rd_q].size;
        end else if (b_cnt_q == CNT_MAX) begin
          // The read pointer still advances so it stays in step with the writer.
          b_state_d       = B_IDLE;
          bank_d[rd_q].st = BK_FREE;
          rd_d            = ~rd_q;
          b_abort         = 1'b1;
        end else begin
          b_cnt_d = b_cnt_q + CNT_ONE;
        end
      end
      B_HOLD: begin
        if (bus.out_ready) begin
          b_state_d   = B_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: b_state_d = B_IDLE;
    endcase

    err_timeout_d = f_abort | b_abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state_q     <= F_IDLE;
      b_state_q     <= B_IDLE;
      bank_q        <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      f_cnt_q       <= '0;
      b_cnt_q       <= '0;
      fwd_start_q   <= 1'b0;
      fwd_len_q     <= '0;
      fwd_bank_q    <= 1'b0;
      bwd_start_q   <= 1'b0;
      bwd_len_q     <= '0;
      bwd_bank_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bits_q    <= '0;
      out_size_q    <= '0;
      err_size_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      f_state_q     <= f_state_d;
      b_state_q     <= b_state_d;
      bank_q        <= bank_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      f_cnt_q       <= f_cnt_d;
      b_cnt_q       <= b_cnt_d;
      fwd_start_q   <= fwd_start_d;
      fwd_len_q     <= fwd_len_d;
      fwd_bank_q    <= fwd_bank_d;
      bwd_start_q   <= bwd_start_d;
      bwd_len_q     <= bwd_len_d;
      bwd_bank_q    <= bwd_bank_d;
      out_valid_q   <= out_valid_d;
      out_bits_q    <= out_bits_d;
      out_size_q    <= out_size_d;
      err_size_q    <= err_size_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.fwd_start   = fwd_start_q;
  assign bus.fwd_len     = fwd_len_q;
  assign bus.fwd_bank    = fwd_bank_q;
  assign bus.bwd_start   = bwd_start_q;
  assign bus.bwd_len     = bwd_len_q;
  assign bus.bwd_bank    = bwd_bank_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bits    = out_bits_q;
  assign bus.out_size    = out_size_q;
  assign bus.err_size    = err_size_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (f_state_q == F_RUN) || (b_state_q != B_IDLE) ||
                           (bank_q[0].st != BK_FREE) || (bank_q[1].st != BK_FREE);

endmodule

// File: tb/tb_vdec1_ctrl.sv
// Directed bench for vdec1_ctrl: single block, overlap, output stall, bad sizes,
// watchdog aborts and mid-run reset, each with hand-computed expectations.
module tb_vdec1_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;

  vdec1_ctrl_if bus();

  vdec1_ctrl #(.TIMEOUT(255), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.fwd_done  = 1'b0;
    bus.bwd_done  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_req(input logic [4:0] size);
    bus.req_size  = size;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_size = 5'd0;
    bus.fwd_done = 1'b0; bus.bwd_done = 1'b0; bus.bwd_info = '0; bus.out_ready = 1'b0;
    step(); step();
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank, bus.bwd_start, bus.bwd_len, bus.bwd_bank,
                bus.out_valid, bus.out_bits, bus.out_size, bus.busy, bus.err_size, bus.err_timeout} !== 61'd0) begin
      errs++; $display("FAIL reset_outputs: got nonzero output vector want all 0");
    end
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %0h want 1", bus.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    send_req(5'd29);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd37, 1'b0}) begin
      errs++; $display("FAIL single_fwd: got start=%0h len=%0d bank=%0h want 1/37/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
    vec++; if ({bus.req_ready, bus.busy} !== 2'b01) begin
      errs++; $display("FAIL single_ready_busy: got ready=%0h busy=%0h want 0/1", bus.req_ready, bus.busy);
    end
    repeat (9) step();
    vec++; if ({bus.fwd_start, bus.fwd_len} !== {1'b0, 6'd37}) begin
      errs++; $display("FAIL single_fwd_hold: got start=%0h len=%0d want 0/37", bus.fwd_start, bus.fwd_len);
    end
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    vec++; if (bus.bwd_start !== 1'b0) begin errs++; $display("FAIL single_bwd_early: got %0h want 0", bus.bwd_start); end
    step();
    vec++; if ({bus.bwd_start, bus.bwd_len, bus.bwd_bank} !== {1'b1, 6'd36, 1'b0}) begin
      errs++; $display("FAIL single_bwd: got start=%0h len=%0d bank=%0h want 1/36/0", bus.bwd_start, bus.bwd_len, bus.bwd_bank);
    end
    repeat (9) step();
    bus.bwd_info = 29'h15A5C3E7; bus.bwd_done = 1'b1; step(); bus.bwd_done = 1'b0;
    vec++; if ({bus.out_valid, bus.out_bits, bus.out_size} !== {1'b1, 29'h15A5C3E7, 5'd29}) begin
      errs++; $display("FAIL single_out: got v=%0h bits=%0h size=%0d want 1/15a5c3e7/29", bus.out_valid, bus.out_bits, bus.out_size);
    end
    step();
    vec++; if ({bus.out_valid, bus.out_bits} !== {1'b1, 29'h15A5C3E7}) begin
      errs++; $display("FAIL single_out_hold: got v=%0h bits=%0h want 1/15a5c3e7", bus.out_valid, bus.out_bits);
    end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    vec++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
      errs++; $display("FAIL single_drain: got v=%0h busy=%0h want 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    send_req(5'd5);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd13, 1'b0}) begin
      errs++; $display("FAIL b2b_fwd0: got start=%0h len=%0d bank=%0h want 1/13/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %0h want 1", bus.req_ready); end
    send_req(5'd12);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd20, 1'b1}) begin
      errs++; $display("FAIL b2b_fwd1: got start=%0h len=%0d bank=%0h want 1/20/1", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
    vec++; if ({bus.bwd_start, bus.bwd_len, bus.bwd_bank} !== {1'b1, 6'd12, 1'b0}) begin
      errs++; $display("FAIL b2b_bwd0: got start=%0h len=%0d bank=%0h want 1/12/0", bus.bwd_start, bus.bwd_len, bus.bwd_bank);
    end
    bus.bwd_info = 29'h1FFFFFFF; bus.fwd_done = 1'b1; bus.bwd_done = 1'b1;
    step();
    bus.fwd_done = 1'b0; bus.bwd_done = 1'b0;
    vec++; if ({bus.out_valid, bus.out_bits, bus.out_size} !== {1'b1, 29'h0000001F, 5'd5}) begin
      errs++; $display("FAIL b2b_out0: got v=%0h bits=%0h size=%0d want 1/1f/5", bus.out_valid, bus.out_bits, bus.out_size);
    end
    step();
    vec++; if ({bus.out_valid, bus.bwd_start} !== 2'b00) begin
      errs++; $display("FAIL b2b_gap: got v=%0h bwd_start=%0h want 0/0", bus.out_valid, bus.bwd_start);
    end
    step();
    vec++; if ({bus.bwd_start, bus.bwd_len, bus.bwd_bank} !== {1'b1, 6'd19, 1'b1}) begin
      errs++; $display("FAIL b2b_bwd1: got start=%0h len=%0d bank=%0h want 1/19/1", bus.bwd_start, bus.bwd_len, bus.bwd_bank);
    end
    bus.bwd_info = 29'h0ABCDE5A; bus.bwd_done = 1'b1; step(); bus.bwd_done = 1'b0;
    vec++; if ({bus.out_valid, bus.out_bits, bus.out_size} !== {1'b1, 29'h00000E5A, 5'd12}) begin
      errs++; $display("FAIL b2b_out1: got v=%0h bits=%0h size=%0d want 1/e5a/12", bus.out_valid, bus.out_bits, bus.out_size);
    end
    step();
    vec++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
      errs++; $display("FAIL b2b_idle: got v=%0h busy=%0h want 0/0", bus.out_valid, bus.busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int blocked;
    do_reset();
    send_req(5'd3);
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    send_req(5'd7);
    bus.bwd_info = 29'h1FFFFFFF; bus.bwd_done = 1'b1; step(); bus.bwd_done = 1'b0;
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_free: got %0h want 1", bus.req_ready); end
    send_req(5'd20);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd28, 1'b0}) begin
      errs++; $display("FAIL stall_fwd3: got start=%0h len=%0d bank=%0h want 1/28/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    vec++; if (bus.req_ready !== 1'b0) begin errs++; $display("FAIL stall_ready_full: got %0h want 0", bus.req_ready); end
    vec++; if ({bus.out_valid, bus.out_bits, bus.out_size} !== {1'b1, 29'h7, 5'd3}) begin
      errs++; $display("FAIL stall_out_hold: got v=%0h bits=%0h size=%0d want 1/7/3", bus.out_valid, bus.out_bits, bus.out_size);
    end
    bus.req_size = 5'd9; bus.req_valid = 1'b1;
    blocked = 0;
    repeat (6) begin
      step();
      if (bus.fwd_start || bus.bwd_start) blocked++;
    end
    vec++; if (blocked !== 0) begin errs++; $display("FAIL stall_no_start: got %0d starts want 0", blocked); end
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    vec++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL stall_release: got %0h want 0", bus.out_valid); end
    step();
    vec++; if ({bus.bwd_start, bus.bwd_len, bus.bwd_bank} !== {1'b1, 6'd14, 1'b1}) begin
      errs++; $display("FAIL stall_bwd1: got start=%0h len=%0d bank=%0h want 1/14/1", bus.bwd_start, bus.bwd_len, bus.bwd_bank);
    end
    bus.bwd_info = 29'h0012345; bus.bwd_done = 1'b1; step(); bus.bwd_done = 1'b0;
    vec++; if ({bus.out_valid, bus.out_bits, bus.out_size} !== {1'b1, 29'h45, 5'd7}) begin
      errs++; $display("FAIL stall_out1: got v=%0h bits=%0h size=%0d want 1/45/7", bus.out_valid, bus.out_bits, bus.out_size);
    end
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_again: got %0h want 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd17, 1'b1}) begin
      errs++; $display("FAIL stall_fwd4: got start=%0h len=%0d bank=%0h want 1/17/1", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
  endtask

  task automatic test_rst_mid();
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rstmid_busy_before: got %0h want 1", bus.busy); end
    rst = 1'b1; step(); rst = 1'b0;
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank, bus.bwd_start, bus.bwd_len, bus.bwd_bank,
                bus.out_valid, bus.out_bits, bus.out_size, bus.busy, bus.err_size, bus.err_timeout} !== 61'd0) begin
      errs++; $display("FAIL rstmid_outputs: got nonzero output vector want all 0");
    end
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL rstmid_req_ready: got %0h want 1", bus.req_ready); end
    send_req(5'd6);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd14, 1'b0}) begin
      errs++; $display("FAIL rstmid_fwd: got start=%0h len=%0d bank=%0h want 1/14/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
  endtask

  task automatic test_bad_size();
    do_reset();
    bus.req_size = 5'd0; bus.req_valid = 1'b1;
    vec++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL bad_ready: got %0h want 1", bus.req_ready); end
    step();
    bus.req_size = 5'd30;
    vec++; if ({bus.err_size, bus.fwd_start, bus.busy} !== 3'b100) begin
      errs++; $display("FAIL bad_size0: got err=%0h start=%0h busy=%0h want 1/0/0", bus.err_size, bus.fwd_start, bus.busy);
    end
    step();
    bus.req_valid = 1'b0;
    vec++; if ({bus.err_size, bus.fwd_start, bus.busy} !== 3'b100) begin
      errs++; $display("FAIL bad_size30: got err=%0h start=%0h busy=%0h want 1/0/0", bus.err_size, bus.fwd_start, bus.busy);
    end
    step();
    vec++; if (bus.err_size !== 1'b0) begin errs++; $display("FAIL bad_pulse_end: got %0h want 0", bus.err_size); end
    bus.fwd_done = 1'b1; bus.bwd_done = 1'b1; step();
    bus.fwd_done = 1'b0; bus.bwd_done = 1'b0; step();
    vec++; if ({bus.busy, bus.bwd_start, bus.out_valid, bus.req_ready} !== 4'b0001) begin
      errs++; $display("FAIL stray_done: got busy=%0h bwd=%0h v=%0h rdy=%0h want 0/0/0/1", bus.busy, bus.bwd_start, bus.out_valid, bus.req_ready);
    end
    send_req(5'd1);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd9, 1'b0}) begin
      errs++; $display("FAIL size1_fwd: got start=%0h len=%0d bank=%0h want 1/9/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
  endtask

  task automatic test_fwd_timeout();
    int npulse, at;
    logic rr, bz;
    do_reset();
    send_req(5'd4);
    npulse = 0; at = 0; rr = 1'b0; bz = 1'b1;
    for (int i = 1; i <= 258; i++) begin
      step();
      if (bus.err_timeout) begin npulse++; at = i; rr = bus.req_ready; bz = bus.busy; end
    end
    vec++; if (npulse !== 1 || at !== 256) begin
      errs++; $display("FAIL fwd_tmo_pulse: got %0d pulses last at %0d want 1 at 256", npulse, at);
    end
    vec++; if ({rr, bz} !== 2'b10) begin
      errs++; $display("FAIL fwd_tmo_state: got ready=%0h busy=%0h want 1/0", rr, bz);
    end
    send_req(5'd8);
    vec++; if ({bus.fwd_start, bus.fwd_len, bus.fwd_bank} !== {1'b1, 6'd16, 1'b0}) begin
      errs++; $display("FAIL fwd_tmo_reuse: got start=%0h len=%0d bank=%0h want 1/16/0", bus.fwd_start, bus.fwd_len, bus.fwd_bank);
    end
  endtask

  task automatic test_bwd_timeout();
    int npulse, at, nvalid;
    do_reset();
    send_req(5'd2);
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    step();
    vec++; if ({bus.bwd_start, bus.bwd_bank} !== 2'b10) begin
      errs++; $display("FAIL bwd_tmo_start: got start=%0h bank=%0h want 1/0", bus.bwd_start, bus.bwd_bank);
    end
    npulse = 0; at = 0; nvalid = 0;
    for (int i = 1; i <= 258; i++) begin
      step();
      if (bus.err_timeout) begin npulse++; at = i; end
      if (bus.out_valid) nvalid++;
    end
    vec++; if (npulse !== 1 || at !== 256 || nvalid !== 0) begin
      errs++; $display("FAIL bwd_tmo_pulse: got %0d pulses at %0d, %0d valid cycles want 1 at 256, 0", npulse, at, nvalid);
    end
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL bwd_tmo_busy: got %0h want 0", bus.busy); end
    send_req(5'd2);
    bus.fwd_done = 1'b1; step(); bus.fwd_done = 1'b0;
    step();
    vec++; if ({bus.bwd_start, bus.bwd_len, bus.bwd_bank} !== {1'b1, 6'd9, 1'b1}) begin
      errs++; $display("FAIL bwd_tmo_next: got start=%0h len=%0d bank=%0h want 1/9/1", bus.bwd_start, bus.bwd_len, bus.bwd_bank);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_rst_mid();
    test_bad_size();
    test_fwd_timeout();
    test_bwd_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
